seg7_avalon_ctrl: RTL and testbench

SEG7_AVALON_CTRL -- requirements
Module: seg7_avalon_ctrl

---
 rtl/seg7_avalon_ctrl.sv | 172 +++++++++++++++++
 tb/tb_seg7_avalon_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_avalon_ctrl.sv
// Avalon-MM slave driving six active-low 7-segment digits with hex decode,
// per-digit blank/dp/blink masks, a raw segment mode and a programmable blink timer.
module seg7_avalon_ctrl #(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  avs_address,
    input  logic        avs_write,
    input  logic        avs_read,
    input  logic [31:0] avs_writedata,
    input  logic [3:0]  avs_byteenable,
    output logic [31:0] avs_readdata,
    output logic [47:0] seg_out
);

    localparam int unsigned DIV_W    = 26;
    localparam int unsigned CTRL_W   = 19;
    localparam int unsigned DIGIT_N  = 6;
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(CLK_HZ / 2);

    logic [23:0]       digits_q,    digits_d;
    logic [CTRL_W-1:0] ctrl_q,      ctrl_d;
    logic [DIV_W-1:0]  blink_div_q, blink_div_d;
    logic [31:0]       raw_lo_q,    raw_lo_d;
    logic [15:0]       raw_hi_q,    raw_hi_d;
    logic [DIV_W-1:0]  cnt_q,       cnt_d;
    logic              phase_q,     phase_d;
    logic [31:0]       readdata_q,  readdata_d;
    logic [47:0]       seg_q,       seg_d;

    logic [31:0] byte_mask_c;
    logic [31:0] rd_sel_c;
    logic [47:0] raw_all_c;
    logic        div_wr_c;

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    // Segment pattern g..a, active-low
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    assign byte_mask_c = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}},
                          {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
    assign raw_all_c   = {raw_hi_q, raw_lo_q};
    assign div_wr_c    = avs_write && (avs_address == 3'd2);

    always_comb begin
        logic [31:0] m;
        digits_d    = digits_q;
        ctrl_d      = ctrl_q;
        blink_div_d = blink_div_q;
        raw_lo_d    = raw_lo_q;
        raw_hi_d    = raw_hi_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        readdata_d  = readdata_q;
        seg_d       = seg_q;
        rd_sel_c    = '0;
        m           = '0;

        // Register writes, byte-masked and trimmed to implemented bits
        if (avs_write) begin
            case (avs_address)
                3'd0: begin
                    m = merge(32'(digits_q), avs_writedata, byte_mask_c);
                    digits_d = m[23:0];
                end
                3'd1: begin
                    m = merge(32'(ctrl_q), avs_writedata, byte_mask_c);
                    ctrl_d = m[CTRL_W-1:0];
                end
                3'd2: begin
                    m = merge(32'(blink_div_q), avs_writedata, byte_mask_c);
                    blink_div_d = m[DIV_W-1:0];
                end
                3'd3: raw_lo_d = merge(raw_lo_q, avs_writedata, byte_mask_c);
                3'd4: begin
                    m = merge(32'(raw_hi_q), avs_writedata, byte_mask_c);
                    raw_hi_d = m[15:0];
                end
                default: ;
            endcase
        end

        case (avs_address)
            3'd0: rd_sel_c = 32'(digits_q);
            3'd1: rd_sel_c = 32'(ctrl_q);
            3'd2: rd_sel_c = 32'(blink_div_q);
            3'd3: rd_sel_c = raw_lo_q;
            3'd4: rd_sel_c = 32'(raw_hi_q);
            3'd5: rd_sel_c = 32'(phase_q);
            default: rd_sel_c = '0;
        endcase
        if (avs_read) begin
            readdata_d = rd_sel_c;
        end

        // Blink timer: counter stays below the divider, so no overflow handling
        if (div_wr_c || (blink_div_q == '0)) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == blink_div_q - DIV_W'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end

        for (int i = 0; i < DIGIT_N; i++) begin
            if (ctrl_q[i]) begin
                seg_d[8*i +: 8] = 8'hFF;
            end else if (ctrl_q[12+i] && !phase_q) begin
                seg_d[8*i +: 8] = 8'hFF;
            end else if (ctrl_q[18]) begin
                seg_d[8*i +: 8] = raw_all_c[8*i +: 8];
            end else begin
                seg_d[8*i +: 8] = {~ctrl_q[6+i], hex_decode(digits_q[4*i +: 4])};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digits_q    <= '0;
            ctrl_q      <= CTRL_W'(6'h3F);
            blink_div_q <= DIV_RST;
            raw_lo_q    <= '0;
            raw_hi_q    <= '0;
            cnt_q       <= '0;
            phase_q     <= 1'b1;
            readdata_q  <= '0;
            seg_q       <= '1;
        end else begin
            digits_q    <= digits_d;
            ctrl_q      <= ctrl_d;
            blink_div_q <= blink_div_d;
            raw_lo_q    <= raw_lo_d;
            raw_hi_q    <= raw_hi_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            readdata_q  <= readdata_d;
            seg_q       <= seg_d;
        end
    end

    assign avs_readdata = readdata_q;
    assign seg_out      = seg_q;

endmodule

// File: tb/tb_seg7_avalon_ctrl.sv
// Randomized bench for seg7_avalon_ctrl against a register-level behavioural model.
module tb_seg7_avalon_ctrl;

    localparam int unsigned CLK_HZ = 50000000;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  avs_address;
    logic        avs_write;
    logic        avs_read;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic [47:0] seg_out;

    always #5 clk = ~clk;

    seg7_avalon_ctrl #(.CLK_HZ(CLK_HZ)) dut (
        .clk           (clk),
        .reset         (reset),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_read      (avs_read),
        .avs_writedata (avs_writedata),
        .avs_byteenable(avs_byteenable),
        .avs_readdata  (avs_readdata),
        .seg_out       (seg_out)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Model state: registers plus blink timer as plain integers
    logic [23:0] m_digits;
    logic [18:0] m_ctrl;
    logic [25:0] m_div;
    logic [31:0] m_lo;
    logic [15:0] m_hi;
    int unsigned m_cnt;
    bit          m_phase;
    logic [47:0] m_seg;
    logic [31:0] m_rd;

    logic [7:0] hex_tbl [16] = '{8'h40, 8'h79, 8'h24, 8'h30, 8'h19, 8'h12, 8'h02, 8'h78,
                                 8'h00, 8'h10, 8'h08, 8'h03, 8'h46, 8'h21, 8'h06, 8'h0E};

    function automatic logic [47:0] model_seg();
        logic [47:0] s;
        logic [47:0] raw;
        raw = {m_hi, m_lo};
        s = '0;
        for (int i = 0; i < 6; i++) begin
            if (m_ctrl[i])                       s[8*i +: 8] = 8'hFF;
            else if (m_ctrl[12+i] && !m_phase)   s[8*i +: 8] = 8'hFF;
            else if (m_ctrl[18])                 s[8*i +: 8] = raw[8*i +: 8];
            else s[8*i +: 8] = {~m_ctrl[6+i], hex_tbl[m_digits[4*i +: 4]][6:0]};
        end
        return s;
    endfunction

    function automatic logic [31:0] model_reg(input logic [2:0] a);
        case (a)
            3'd0: return {8'h0, m_digits};
            3'd1: return {13'h0, m_ctrl};
            3'd2: return {6'h0, m_div};
            3'd3: return m_lo;
            3'd4: return {16'h0, m_hi};
            3'd5: return {31'h0, m_phase};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_digits = '0;
        m_ctrl   = 19'h3F;
        m_div    = 26'(CLK_HZ / 2);
        m_lo     = '0;
        m_hi     = '0;
        m_cnt    = 0;
        m_phase  = 1'b1;
        m_seg    = '1;
        m_rd     = '0;
    endtask

    // One clock: drive, predict, clock, compare
    task automatic cycle(input bit rst, input bit wr, input bit rd, input logic [2:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] bm, old, nw;
        logic [47:0] n_seg;
        logic [31:0] n_rd;
        reset = rst; avs_write = wr; avs_read = rd;
        avs_address = a; avs_writedata = wd; avs_byteenable = be;
        n_seg = model_seg();
        n_rd  = rd ? model_reg(a) : m_rd;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            bm = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
            old = model_reg(a);
            nw  = (old & ~bm) | (wd & bm);
            if (wr) begin
                if (a == 3'd0) m_digits = nw[23:0];
                if (a == 3'd1) m_ctrl   = nw[18:0];
                if (a == 3'd4) m_hi     = nw[15:0];
                if (a == 3'd3) m_lo     = nw;
            end
            if (wr && a == 3'd2) begin
                m_cnt = 0; m_phase = 1'b1;
            end else if (m_div == 0) begin
                m_cnt = 0; m_phase = 1'b1;
            end else if (m_cnt == m_div - 1) begin
                m_cnt = 0; m_phase = ~m_phase;
            end else begin
                m_cnt++;
            end
            if (wr && a == 3'd2) m_div = nw[25:0];
            m_seg = n_seg;
            m_rd  = n_rd;
        end
        check("seg_out", 64'(seg_out), 64'(m_seg));
        if (rd || rst) check("readdata", 64'(avs_readdata), 64'(m_rd));
        reset = 1'b0; avs_write = 1'b0; avs_read = 1'b0;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
        cycle(1'b0, 1'b1, 1'b0, a, wd, 4'hF);
    endtask

    task automatic rd_reg(input logic [2:0] a);
        cycle(1'b0, 1'b0, 1'b1, a, 32'h0, 4'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    endtask

    initial begin
        model_reset();
        reset = 1'b1; avs_write = 1'b0; avs_read = 1'b0;
        avs_address = '0; avs_writedata = '0; avs_byteenable = '0;
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
        check("reset_seg", 64'(seg_out), 64'h0000_FFFF_FFFF_FFFF);
        for (int a = 0; a < 6; a++) rd_reg(3'(a));

        // Hex decode with dp off on all digits
        wr_reg(3'd0, 32'h0000_A810);
        wr_reg(3'd1, 32'h0);
        idle(1);
        check("hex_decode", 64'(seg_out), 64'h0000_C0C0_8880_F9C0);

        // Single-byte write to digits 2..3
        cycle(1'b0, 1'b1, 1'b0, 3'd0, 32'h0000_5500, 4'b0010);
        rd_reg(3'd0);
        check("byteenable_merge", 64'(avs_readdata), 64'h0000_0000_0000_5510);

        // Blink digit 0 with half-period 3, then freeze with divider 0
        wr_reg(3'd1, 32'h0000_1000);
        wr_reg(3'd2, 32'd3);
        for (int i = 0; i < 14; i++) rd_reg(3'd5);
        wr_reg(3'd2, 32'd0);
        idle(3);
        check("blink_hold", 64'(seg_out[7:0]), 64'(8'hC0));
        rd_reg(3'd5);
        check("phase_forced", 64'(avs_readdata), 64'h1);

        // Raw mode with digit 1 blanked
        wr_reg(3'd3, 32'h1234_5678);
        wr_reg(3'd1, 32'h0004_0002);
        idle(1);
        check("raw_mode", 64'(seg_out[31:0]), 64'h1234_FF78);

        // Reset during blinking, coincident with a DIGITS write
        wr_reg(3'd1, 32'h0003_F000);
        wr_reg(3'd2, 32'd2);
        idle(5);
        cycle(1'b1, 1'b1, 1'b0, 3'd0, 32'h00FF_FFFF, 4'hF);
        check("reset_wins_seg", 64'(seg_out), 64'h0000_FFFF_FFFF_FFFF);
        for (int a = 0; a < 6; a++) rd_reg(3'(a));

        // Unused addresses and read-only STATUS
        rd_reg(3'd6);
        check("addr6_zero", 64'(avs_readdata), 64'h0);
        rd_reg(3'd7);
        check("addr7_zero", 64'(avs_readdata), 64'h0);
        wr_reg(3'd5, 32'h0);
        rd_reg(3'd5);

        // Random traffic; small dividers so blinking is exercised
        for (int n = 0; n < 3000; n++) begin
            int op;
            logic [2:0]  a;
            logic [31:0] wd;
            op = int'($urandom_range(0, 9));
            a  = 3'($urandom_range(0, 7));
            wd = $urandom;
            if (a == 3'd2) wd = $urandom_range(0, 6);
            cycle($urandom_range(0, 99) == 0, op < 4, op >= 4 && op < 7, a, wd,
                  4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
